// File: rtl/cic3_row_stream.sv
// cic3_row_stream
// Row of NUM_CHANNELS third-order CIC decimators, one per 1-bit sigma-delta
// channel. All channels share the decimation ratio R = 2^dec_log2. Each
// decimated frame is captured into a result buffer and then streamed out one
// enabled channel per beat over a valid/ready port.
//
// Ports
//   clk            rising-edge clock; decimation is a clock enable
//   reset_n        synchronous reset, active low
//   enable         run filters; low holds integrators/combs/counter cleared
//   dec_log2       log2(R), loaded (clamped to 1..MAX_LOG2_DEC) while enable=0
//   chan_en        per-channel filter and readout enable
//   in             modulator bits, one per channel
//   out_data       filtered sample of channel out_chan
//   out_chan       channel index of out_data
//   out_valid      beat available
//   out_ready      consumer accepts the beat when out_valid && out_ready
//   frame_done     one-cycle pulse after the last beat of a frame is accepted
//   overrun        sticky: a decimated frame was dropped (buffer busy)
//   clear_overrun  synchronous clear of overrun (a new drop wins)
module cic3_row_stream #(
  parameter int  NUM_CHANNELS = 24,
  parameter int  MAX_LOG2_DEC = 8,
  parameter int  OUT_WIDTH    = 25,
  localparam int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [3:0]              dec_log2,
  input  logic [NUM_CHANNELS-1:0] chan_en,
  input  logic [NUM_CHANNELS-1:0] in,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic [CH_W-1:0]         out_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_done,
  output logic                    overrun,
  input  logic                    clear_overrun
);

  localparam logic [3:0] MAX_DEC4 = 4'(MAX_LOG2_DEC);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [CH_W-1:0] first_set(input logic [NUM_CHANNELS-1:0] m);
    first_set = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) first_set = CH_W'(i);
    end
  endfunction

  // ---------------- decimation ratio and counter ----------------
  logic [3:0]              dec_q, dec_d;
  logic [MAX_LOG2_DEC-1:0] cnt_q;
  logic [MAX_LOG2_DEC:0]   r_full;
  logic                    dec_stb;

  always_comb begin
    dec_d = dec_log2;
    if (dec_log2 == 4'd0)          dec_d = 4'd1;
    else if (dec_log2 > MAX_DEC4)  dec_d = MAX_DEC4;
  end

  assign r_full  = (MAX_LOG2_DEC + 1)'(1) << dec_q;
  assign dec_stb = enable && ({1'b0, cnt_q} == r_full - 1'b1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_q <= MAX_DEC4;
      cnt_q <= '0;
    end else if (!enable) begin
      dec_q <= dec_d;
      cnt_q <= '0;
    end else if (dec_stb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---------------- per-channel integrators and combs ----------------
  logic [OUT_WIDTH-1:0] comb_y [NUM_CHANNELS];

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic [OUT_WIDTH-1:0] i1_q, i2_q, i3_q;
    logic [OUT_WIDTH-1:0] d1_q, d2_q, d3_q;
    logic [OUT_WIDTH-1:0] x_w, c1_w, c2_w;

    // The comb input is the post-update I3 of the strobe cycle; with zeroed
    // history this makes the third decimated frame exact.
    assign x_w        = i3_q + i2_q;
    assign c1_w       = x_w - d1_q;
    assign c2_w       = c1_w - d2_q;
    assign comb_y[gi] = c2_w - d3_q;

    always_ff @(posedge clk) begin
      if (!reset_n || !enable || !chan_en[gi]) begin
        i1_q <= '0;
        i2_q <= '0;
        i3_q <= '0;
        d1_q <= '0;
        d2_q <= '0;
        d3_q <= '0;
      end else begin
        i1_q <= i1_q + {{(OUT_WIDTH-1){1'b0}}, in[gi]};
        i2_q <= i2_q + i1_q;
        i3_q <= i3_q + i2_q;
        if (dec_stb) begin
          d1_q <= x_w;
          d2_q <= c1_w;
          d3_q <= c2_w;
        end
      end
    end
  end

  // ---------------- result buffer and readout ----------------
  state_t                  state_q;
  logic [NUM_CHANNELS-1:0] pend_q;      // snapshot channels not yet presented
  logic [OUT_WIDTH-1:0]    res_q [NUM_CHANNELS];
  logic [OUT_WIDTH-1:0]    out_data_q;
  logic [CH_W-1:0]         out_chan_q;
  logic                    out_valid_q, frame_done_q, overrun_q;
  logic [CH_W-1:0]         first_new, first_pend;
  logic                    last_acc, buf_free;

  assign first_new  = first_set(chan_en);
  assign first_pend = first_set(pend_q);
  // Accepting the final beat frees the buffer in that same cycle.
  assign last_acc   = (state_q == SEND) && out_ready && (pend_q == '0);
  assign buf_free   = (state_q == IDLE) || last_acc;

  always_ff @(posedge clk) begin
    if (dec_stb && buf_free) begin
      for (int c = 0; c < NUM_CHANNELS; c++) res_q[c] <= comb_y[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (state_q == SEND && out_ready) begin
        if (pend_q != '0) begin
          out_chan_q <= first_pend;
          out_data_q <= res_q[first_pend];
          pend_q     <= pend_q & ~(NUM_CHANNELS'(1) << first_pend);
        end else begin
          out_valid_q  <= 1'b0;
          frame_done_q <= 1'b1;
          state_q      <= IDLE;
        end
      end

      // A capture overrides the end-of-frame return to IDLE above, so a new
      // frame can start in the same cycle the previous one finishes.
      if (dec_stb && buf_free && chan_en != '0) begin
        state_q     <= SEND;
        out_valid_q <= 1'b1;
        out_chan_q  <= first_new;
        out_data_q  <= comb_y[first_new];
        pend_q      <= chan_en & ~(NUM_CHANNELS'(1) << first_new);
      end

      if (dec_stb && !buf_free) overrun_q <= 1'b1;
      else if (clear_overrun)   overrun_q <= 1'b0;
    end
  end

  assign out_data   = out_data_q;
  assign out_chan   = out_chan_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic3_row_stream.sv
// tb_cic3_row_stream
// Directed bench for cic3_row_stream. Stimulus pushes expected beats (channel,
// value, last-of-frame) into a queue; a monitor on the falling edge pops one
// entry per accepted beat and checks it, plus frame_done on the next cycle.
// Beats arriving while the queue is empty are ignored.
module tb_cic3_row_stream;
  localparam int N  = 24;
  localparam int OW = 25;
  localparam int CW = 5;
  localparam logic [N-1:0] ALL = {N{1'b1}};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [3:0]    dec_log2 = 4'd2;
  logic [N-1:0]  chan_en = '0;
  logic [N-1:0]  in_bits = '0;
  logic          out_ready = 1'b1;
  logic          clear_overrun = 1'b0;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_chan;
  logic          out_valid, frame_done, overrun;

  cic3_row_stream #(.NUM_CHANNELS(N), .MAX_LOG2_DEC(8), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dec_log2(dec_log2),
    .chan_en(chan_en), .in(in_bits), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done),
    .overrun(overrun), .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ch;
    logic [OW-1:0] data;
    bit            chk;
    bit            last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   fd_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue one frame: enabled channels in ascending order; channel value is
  // val where hot is set, else 0; chk=0 marks start-up transient frames.
  task automatic push_frame(input logic [N-1:0] en, input logic [N-1:0] hot,
                            input logic [OW-1:0] val, input bit chk);
    exp_t e;
    int   lastc = -1;
    for (int c = 0; c < N; c++) if (en[c]) lastc = c;
    for (int c = 0; c < N; c++) begin
      if (en[c]) begin
        e.ch   = CW'(c);
        e.data = hot[c] ? val : '0;
        e.chk  = chk;
        e.last = (c == lastc);
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: compare accepted beats against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (fd_pending) begin
      check("frame_done_after_last", {31'd0, frame_done}, 32'd1);
      fd_pending = 1'b0;
    end
    if (reset_n && out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      $display("beat ch=%0d data=%0d exp_ch=%0d exp_data=%0d%s", out_chan, out_data,
               e.ch, e.data, e.chk ? "" : " (transient, value not checked)");
      check("beat_chan", {27'd0, out_chan}, {27'd0, e.ch});
      if (e.chk) check("beat_data", {7'd0, out_data}, {7'd0, e.data});
      if (e.last) fd_pending = 1'b1;
    end
  end

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while ((sb.size() > 0 || fd_pending) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() > 0 || fd_pending) begin
      errors++;
      $display("FAIL %s: timeout, %0d beats outstanding, required 0", name, sb.size());
      sb.delete();
      fd_pending = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 100) begin
      step();
      n++;
    end
    check(name, {31'd0, out_valid}, 32'd0);
  endtask

  // One filter run: configure with enable low, queue n_dc transient frames and
  // n_chk exact frames, run until all are seen, then stop and drain.
  task automatic run_frames(input logic [3:0] dl, input logic [3:0] dl_after,
                            input logic [N-1:0] en, input logic [N-1:0] hot,
                            input logic [OW-1:0] val, input int n_dc, input int n_chk,
                            input int budget, input string name);
    enable    = 1'b0;
    dec_log2  = dl;
    chan_en   = en;
    in_bits   = hot;
    out_ready = 1'b1;
    repeat (3) step();
    for (int f = 0; f < n_dc; f++) push_frame(en, hot, val, 1'b0);
    for (int f = 0; f < n_chk; f++) push_frame(en, hot, val, 1'b1);
    enable = 1'b1;
    step();
    dec_log2 = dl_after;
    wait_empty(budget, name);
    enable = 1'b0;
    drain({name, "_drain"});
  endtask

  initial begin
    int n;
    int busy;

    // Reset state
    repeat (3) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {7'd0, out_data}, 32'd0);
    check("rst_out_chan", {27'd0, out_chan}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;
    step();

    // 1: R=4, all channels, all ones -> 64; streaming is slower than R so
    // frames are dropped, and the next capture lands on the last-beat cycle.
    run_frames(4'd2, 4'd2, ALL, ALL, 25'd64, 1, 2, 400, "t1_r4_all");
    check("t1_overrun_set", {31'd0, overrun}, 32'd1);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("t1_overrun_clear", {31'd0, overrun}, 32'd0);

    // dec_log2=0 clamps to R=2 -> 8
    run_frames(4'd0, 4'd0, 24'h000001, 24'h000001, 25'd8, 2, 2, 200, "clamp0_r2");

    // 3: chan_en 0x000101, R=8 -> channels 0 and 8, value 512, no drops
    run_frames(4'd3, 4'd3, 24'h000101, 24'h000101, 25'd512, 2, 2, 300, "t3_r8_ch0_8");
    check("t3_no_overrun", {31'd0, overrun}, 32'd0);

    // 2: dec_log2=15 clamps to R=256; only channel 5 driven -> 2^24, others 0
    run_frames(4'd15, 4'd15, ALL, 24'h000020, 25'd16777216, 2, 2, 2000, "t2_r256_ch5");

    // 5: changing dec_log2 while enabled keeps R=8; after re-enable R=32
    run_frames(4'd3, 4'd5, 24'h000001, 24'h000001, 25'd512, 2, 2, 300, "t5_hold_r8");
    run_frames(4'd5, 4'd5, ALL, ALL, 25'd32768, 2, 2, 500, "t5_r32");

    // Snapshot with no enabled channels: no beats, no frame_done
    dec_log2 = 4'd2;
    chan_en  = '0;
    in_bits  = ALL;
    repeat (3) step();
    enable = 1'b1;
    busy = 0;
    repeat (30) begin
      step();
      if (out_valid || frame_done) busy++;
    end
    enable = 1'b0;
    check("empty_snapshot_quiet", busy, 32'd0);

    // 4: R=2 stall. Run into steady state, then hold ready low on a chan-0 beat.
    dec_log2  = 4'd1;
    chan_en   = ALL;
    out_ready = 1'b1;
    repeat (3) step();
    enable = 1'b1;
    repeat (40) step();
    check("t4_overrun_running", {31'd0, overrun}, 32'd1);
    n = 0;
    while (!(out_valid && out_chan == 0) && n < 100) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    repeat (4) begin
      step();
      check("t4_stall_valid", {31'd0, out_valid}, 32'd1);
      check("t4_stall_chan", {27'd0, out_chan}, 32'd0);
      check("t4_stall_data", {7'd0, out_data}, 32'd8);
    end
    enable = 1'b0;
    step();
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("t4_overrun_cleared", {31'd0, overrun}, 32'd0);
    enable = 1'b1;
    repeat (4) step();
    check("t4_overrun_on_drop", {31'd0, overrun}, 32'd1);
    check("t4_stall_data_kept", {7'd0, out_data}, 32'd8);
    enable = 1'b0;
    step();
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    check("t4_overrun_cleared2", {31'd0, overrun}, 32'd0);
    push_frame(ALL, ALL, 25'd8, 1'b1);
    out_ready = 1'b1;
    wait_empty(100, "t4_release");
    drain("t4_drain");

    // 6: reset mid-frame
    dec_log2 = 4'd2;
    repeat (3) step();
    enable = 1'b1;
    n = 0;
    while (!(out_valid && out_chan == 5) && n < 200) begin
      step();
      n++;
    end
    check("t6_reached_ch5", {27'd0, out_chan}, 32'd5);
    reset_n = 1'b0;
    enable  = 1'b0;
    step();
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    check("t6_rst_chan", {27'd0, out_chan}, 32'd0);
    check("t6_rst_data", {7'd0, out_data}, 32'd0);
    reset_n = 1'b1;
    busy = 0;
    repeat (10) begin
      step();
      if (out_valid || frame_done) busy++;
    end
    check("t6_quiet_after_reset", busy, 32'd0);
    run_frames(4'd2, 4'd2, ALL, ALL, 25'd64, 1, 2, 400, "t6_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
